// File: rtl/referee_param.sv
// Routes words from one show-ahead source FIFO to NUM_CH destination FIFOs,
// by class field (MODE 0) or round-robin over non-full channels (MODE 1).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitration disabled, no pops
// RUN   | popping one word per cycle whenever the destination can accept
// STALL | word waiting but destination full; re-enter RUN when it drains
module referee_param #(
   parameter int DATA_WIDTH = 10,
   parameter int NUM_CH     = 4,
   parameter int SEL_WIDTH  = 2,
   parameter int MODE       = 0,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          empty,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic [NUM_CH-1:0]             almost_full,
   output logic                          pop,
   output logic [NUM_CH-1:0]             push,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic [1:0]                    state,
   output logic [NUM_CH*CNT_WIDTH-1:0]   push_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      STALL = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [SEL_WIDTH-1:0]  rr_ptr;
   logic [SEL_WIDTH-1:0]  dest_cls, dest_rr, dest, idx;
   logic                  found;
   logic                  can_go;
   logic [CNT_WIDTH-1:0]  cnt [NUM_CH];

   // Round-robin search: first non-full channel starting at rr_ptr
   always_comb begin
      dest_rr = rr_ptr;
      found   = 1'b0;
      idx     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = rr_ptr + SEL_WIDTH'(i);
         if (!found && !almost_full[idx]) begin
            dest_rr = idx;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      dest_cls = data_in[DATA_WIDTH-1 -: SEL_WIDTH];
      dest     = (MODE == 0) ? dest_cls : dest_rr;
      if (MODE == 0)
         can_go = !empty && !almost_full[dest];
      else
         can_go = !empty && !(&almost_full);
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) state_d = RUN;
         end
         RUN: begin
            pop = enable && can_go;
            if (!enable)
               state_d = IDLE;
            else if (!empty && !can_go)
               state_d = STALL;
         end
         STALL: begin
            if (!enable)
               state_d = IDLE;
            else if (can_go || empty)
               state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         push     <= '0;
         data_out <= '0;
         rr_ptr   <= '0;
      end else begin
         state_q <= state_d;
         push    <= pop ? ({{(NUM_CH-1){1'b0}}, 1'b1} << dest) : '0;
         if (pop) begin
            data_out <= data_in;
            if (MODE != 0) rr_ptr <= dest + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            cnt[g] <= '0;
         else if (push[g])
            cnt[g] <= cnt[g] + 1'b1;
      end
      assign push_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
   end

   assign state = state_q;

endmodule

// File: tb/tb_referee_param.sv
// Directed bench: u0 is a class-routed instance with 2-bit counters,
// u1 a round-robin instance with default counters.
module tb_referee_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable0, empty0, enable1, empty1;
   logic [9:0]  data0, data1;
   logic [3:0]  af0, af1;
   logic        pop0, pop1;
   logic [3:0]  push0, push1;
   logic [9:0]  dout0, dout1;
   logic [1:0]  state0, state1;
   logic [7:0]  count0;
   logic [31:0] count1;

   int n_pass  = 0;
   int n_total = 0;

   referee_param #(.DATA_WIDTH(10), .NUM_CH(4), .SEL_WIDTH(2), .MODE(0), .CNT_WIDTH(2)) u0 (
      .clk(clk), .reset(reset), .enable(enable0), .empty(empty0), .data_in(data0),
      .almost_full(af0), .pop(pop0), .push(push0), .data_out(dout0), .state(state0),
      .push_count(count0));

   referee_param #(.DATA_WIDTH(10), .NUM_CH(4), .SEL_WIDTH(2), .MODE(1), .CNT_WIDTH(8)) u1 (
      .clk(clk), .reset(reset), .enable(enable1), .empty(empty1), .data_in(data1),
      .almost_full(af1), .pop(pop1), .push(push1), .data_out(dout1), .state(state1),
      .push_count(count1));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      logic [9:0] words0 [4];
      logic [3:0] exp_rr [6];
      words0 = '{10'h0AA, 10'h1BB, 10'h2CC, 10'h3DD};
      exp_rr = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

      reset = 1'b0;
      enable0 = 1'b0; empty0 = 1'b1; data0 = '0; af0 = '0;
      enable1 = 1'b0; empty1 = 1'b1; data1 = '0; af1 = '0;
      #12;
      chk("rst_state0", 32'(state0), 32'd0);
      chk("rst_pop0",   32'(pop0),   32'd0);
      chk("rst_push0",  32'(push0),  32'd0);
      chk("rst_dout0",  32'(dout0),  32'd0);
      chk("rst_count0", 32'(count0), 32'd0);
      chk("rst_state1", 32'(state1), 32'd0);
      chk("rst_count1", count1,      32'd0);

      // class routing, four back-to-back words
      reset = 1'b1;
      enable0 = 1'b1; empty0 = 1'b0; data0 = 10'h0AA;
      #1;
      chk("idle_no_pop", 32'(pop0), 32'd0);
      tick();
      chk("idle_to_run", 32'(state0), 32'd1);
      for (int i = 0; i < 4; i++) begin
         data0 = words0[i];
         #1;
         chk("b2b_pop", 32'(pop0), 32'd1);
         tick();
         if (i == 3) empty0 = 1'b1;
         chk("b2b_push", 32'(push0), 32'(4'b0001 << i));
         chk("b2b_dout", 32'(dout0), 32'(words0[i]));
      end
      tick();
      chk("idle_push_zero", 32'(push0), 32'd0);
      chk("dout_hold", 32'(dout0), 32'h3DD);
      chk("count_each1", 32'(count0), 32'h55);

      // stall on full destination, then resume
      data0 = 10'h1BB; af0 = 4'b0010; empty0 = 1'b0;
      #1;
      chk("full_no_pop", 32'(pop0), 32'd0);
      tick();
      chk("stall_state", 32'(state0), 32'd2);
      af0 = 4'b0000;
      #1;
      chk("stall_no_pop", 32'(pop0), 32'd0);
      tick();
      chk("stall_to_run", 32'(state0), 32'd1);
      #1;
      chk("resume_pop", 32'(pop0), 32'd1);
      tick();
      empty0 = 1'b1;
      af0 = 4'b0010;
      #1;
      chk("resume_push", 32'(push0), 32'(4'b0010));
      chk("resume_dout", 32'(dout0), 32'h1BB);
      af0 = 4'b0000;
      tick();
      chk("resume_push_done", 32'(push0), 32'd0);
      chk("count_after_stall", 32'(count0), 32'h59);

      // enable dropped right after a pop
      data0 = 10'h2CC; empty0 = 1'b0;
      #1;
      chk("en_drop_pop", 32'(pop0), 32'd1);
      tick();
      enable0 = 1'b0;
      #1;
      chk("en_low_no_pop", 32'(pop0), 32'd0);
      chk("inflight_push", 32'(push0), 32'(4'b0100));
      chk("inflight_dout", 32'(dout0), 32'h2CC);
      chk("still_run", 32'(state0), 32'd1);
      tick();
      chk("en_drop_idle", 32'(state0), 32'd0);
      chk("en_drop_push0", 32'(push0), 32'd0);
      chk("idle_pop_nonempty", 32'(pop0), 32'd0);
      chk("count_after_drop", 32'(count0), 32'h69);

      // async reset between pop and push visibility
      enable0 = 1'b1; data0 = 10'h3DD;
      tick();
      #1;
      chk("pre_rst_pop", 32'(pop0), 32'd1);
      tick();
      chk("pre_rst_push", 32'(push0), 32'(4'b1000));
      reset = 1'b0;
      #1;
      chk("arst_push", 32'(push0), 32'd0);
      chk("arst_dout", 32'(dout0), 32'd0);
      chk("arst_count", 32'(count0), 32'd0);
      chk("arst_state", 32'(state0), 32'd0);
      reset = 1'b1;
      tick();
      chk("post_rst_run", 32'(state0), 32'd1);
      chk("post_rst_no_push", 32'(push0), 32'd0);

      // 2-bit counter wrap on channel 0
      data0 = 10'h0AA;
      tick();
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) empty0 = 1'b1;
         tick();
         chk("cnt_wrap", 32'(count0), 32'(k % 4));
      end

      // round-robin skipping full channel 2
      enable1 = 1'b1; af1 = 4'b0100;
      tick();
      chk("rr_run", 32'(state1), 32'd1);
      empty1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         data1 = 10'h100 + 10'(i);
         if (i == 5) af1 = 4'b0000;
         #1;
         chk("rr_pop", 32'(pop1), 32'd1);
         tick();
         if (i == 5) empty1 = 1'b1;
         chk("rr_push", 32'(push1), 32'(exp_rr[i]));
         chk("rr_dout", 32'(dout1), 32'(10'h100 + 10'(i)));
      end
      tick();
      chk("rr_counts", count1, 32'h01010202);

      // all channels full: stall, then drain of source returns to RUN
      af1 = 4'b1111; empty1 = 1'b0;
      #1;
      chk("rr_full_no_pop", 32'(pop1), 32'd0);
      tick();
      chk("rr_stall", 32'(state1), 32'd2);
      empty1 = 1'b1;
      tick();
      chk("rr_stall_to_run", 32'(state1), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/referee_param.md
REFEREE_PARAM -- requirements
Module: referee_param

Interface
REQ-001 Parameter DATA_WIDTH, default 10: width of data word carried from source FIFO to destination FIFOs.
REQ-002 Parameter NUM_CH, default 4: number of destination channels; power of two, 2..16.
REQ-003 Parameter SEL_WIDTH, default 2: log2(NUM_CH); width of class field and round-robin pointer.
REQ-004 Parameter MODE, default 0: 0 = class routing, destination = data_in[DATA_WIDTH-1 -: SEL_WIDTH]; 1 = round-robin routing.
REQ-005 Parameter CNT_WIDTH, default 8: width of each per-channel push counter.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-008 enable  input  1  1 = arbitration allowed; 0 = no new pops.
REQ-009 empty  input  1  source FIFO empty flag.
REQ-010 data_in  input  DATA_WIDTH  source FIFO head word, valid in same cycle as pop (show-ahead).
REQ-011 almost_full  input  NUM_CH  per-destination almost-full flags; bit i = channel i.
REQ-012 pop  output  1  combinational read strobe to source FIFO.
REQ-013 push  output  NUM_CH  registered one-hot write strobes to destination FIFOs.
REQ-014 data_out  output  DATA_WIDTH  registered word accompanying push.
REQ-015 state  output  2  current FSM state: 00 IDLE, 01 RUN, 10 STALL.
REQ-016 push_count  output  NUM_CH*CNT_WIDTH  per-channel push counters, channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-017 dest SHALL be: MODE 0, class field of data_in; MODE 1, first channel at or after rr_ptr (modulo NUM_CH) with almost_full=0.
REQ-018 can_go SHALL be 1 when empty=0 and almost_full[dest]=0 (MODE 1: at least one almost_full bit is 0).
REQ-019 pop SHALL equal (state==RUN) & enable & can_go; pop SHALL be 0 in IDLE and STALL.
REQ-020 Cycle after pop=1, push SHALL be one-hot at bit dest and data_out SHALL hold the popped data_in; latency exactly 1 cycle.
REQ-021 Cycle after pop=0, push SHALL be all zeros; data_out SHALL hold its previous value.
REQ-022 Back-to-back pops SHALL be supported: one word per cycle while can_go stays 1.
REQ-023 IDLE->RUN when enable=1; RUN/STALL->IDLE when enable=0; enable has priority over all other transitions.
REQ-024 RUN->STALL when enable=1, empty=0, can_go=0; RUN stays RUN when empty=1.
REQ-025 STALL->RUN when can_go=1 or empty=1; otherwise remain STALL.
REQ-026 Push registered in the cycle enable falls SHALL still be issued next cycle (no in-flight word lost).
REQ-027 MODE 1: on each pop rr_ptr SHALL become (dest+1) mod NUM_CH; rr_ptr unchanged without pop.
REQ-028 push_count[i] SHALL increment by 1 each cycle push[i]=1, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-029 almost_full changes SHALL only affect the pop decision of the current cycle; a registered push is never cancelled.

Reset
REQ-030 While reset=0: state=IDLE, pop=0, push=0, data_out=0, push_count all 0, rr_ptr=0.
REQ-031 Reset asserted mid-transfer SHALL discard the pending push; no push after reset releases until a new pop.
REQ-032 First possible pop SHALL be the cycle after the first clock edge with reset=1 and enable=1 (IDLE->RUN).

Verification
REQ-033 MODE 0, NUM_CH=4, enable=1, FIFO holds 0x0AA,0x1BB,0x2CC,0x3DD, almost_full=0 -> four pops back-to-back; push=0001,0010,0100,1000 one cycle later with matching data_out; push_count each 1.
REQ-034 MODE 0, head 0x1BB, almost_full=0010 -> state STALL, pop=0; clear almost_full -> RUN, pop=1, next cycle push=0010, data_out=0x1BB.
REQ-035 MODE 1, 5 words, almost_full=0100 -> destinations 0,1,3,0,1; push never on channel 2; rr_ptr ends at 2.
REQ-036 enable dropped on cycle of a pop -> push still issued next cycle, then state IDLE, pop=0 despite empty=0.
REQ-037 reset pulsed low asynchronously between pop and push -> push=0, data_out=0, counters 0, state IDLE immediately.
REQ-038 CNT_WIDTH=2, 5 words to channel 0 -> push_count[0] sequence 1,2,3,0,1.
